// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: 2-flop synchroniser, 3-sample majority vote, parity/framing/overrun status.
// Latency: word valid one Clk after the final stop-bit decision tick (~half a bit before frame end).
// Backpressure: single output register; a frame completing while the held word is unaccepted is dropped and flagged as overrun.
module uart_rx_frame #(
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int SYSCLOCK_FREQ = 100000000,
    parameter int BAUDRATE      = 9600,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_In,
    input  logic                 Rx_Ready,
    output logic                 Rx_Valid,
    output logic [DATA_BITS-1:0] Rx_Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 RTS
);

    localparam int TICK_DIV = SYSCLOCK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("uart_rx_frame: TICK_DIV must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
        if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_oversample
            $error("uart_rx_frame: OVERSAMPLE must be 8 or 16");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   sync1;
    logic                   rxs;
    logic                   armed;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [SW-1:0]          samp_cnt;
    logic                   samp_a;
    logic                   samp_b;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_flag;
    logic                   frm_flag;

    logic                   start_det;
    logic                   decide;
    logic                   maj;
    logic                   exp_par;
    logic                   complete;
    logic                   frm_final;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= Rx_In;
            rxs   <= sync1;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: all transitions out of a bit happen at that bit's decision tick.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_det) next_state = S_START;
            S_START:  if (decide) next_state = maj ? S_IDLE : S_DATA;
            S_DATA:   if (decide && bit_cnt == BIT_LAST) next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (decide) next_state = S_STOP;
            S_STOP:   if (decide && stop_cnt == STOP_LAST) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Decode of tick, bit decision, majority vote and frame completion.
    always_comb begin
        tick      = (tick_cnt == TICK_LAST);
        start_det = (state == S_IDLE) && !rxs && armed;
        decide    = (state != S_IDLE) && tick && (samp_cnt == SAMP_C);
        maj       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        exp_par   = (PARITY == 1) ? ~^shreg : ^shreg;
        complete  = (state == S_STOP) && decide && (stop_cnt == STOP_LAST);
        frm_final = frm_flag | !maj;
    end

    // Tick and sample counters; held at zero in IDLE so bit phase starts at the detected falling edge.
    always_ff @(posedge Clk) begin
        if (Rst || state == S_IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Capture the first two of the three vote samples; the third is the live line at the decision tick.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == SAMP_A) samp_a <= rxs;
            if (samp_cnt == SAMP_B) samp_b <= rxs;
        end
    end

    // Frame datapath: data shift register, bit/stop counters and per-frame error flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            if (state != S_DATA)  bit_cnt <= '0;
            else if (decide)      bit_cnt <= bit_cnt + 1'b1;

            if (state != S_STOP)  stop_cnt <= 1'b0;
            else if (decide)      stop_cnt <= 1'b1;

            if (state == S_DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};

            if (start_det)                            par_flag <= 1'b0;
            else if (state == S_PARITY && decide)     par_flag <= (maj != exp_par);

            if (start_det)                            frm_flag <= 1'b0;
            else if (state == S_STOP && decide && !maj) frm_flag <= 1'b1;
        end
    end

    // Arming: a bad stop bit disarms start detection until the line is seen high in IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            armed <= 1'b0;
        end else if (state == S_STOP && decide && !maj) begin
            armed <= 1'b0;
        end else if (state == S_IDLE && rxs) begin
            armed <= 1'b1;
        end
    end

    // Output register with valid/ready handshake; a completion that cannot load only raises overrun.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rx_Valid    <= 1'b0;
            Rx_Data_Out <= '0;
            Rx_Error    <= 3'b000;
        end else if (complete) begin
            if (!Rx_Valid || Rx_Ready) begin
                Rx_Valid    <= 1'b1;
                Rx_Data_Out <= shreg;
                Rx_Error    <= {1'b0, frm_final, par_flag};
            end else begin
                Rx_Error[2] <= 1'b1;
            end
        end else if (Rx_Valid && Rx_Ready) begin
            Rx_Valid <= 1'b0;
            Rx_Error <= 3'b000;
        end
    end

    assign RTS = !Rx_Valid;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: instance A is an 8N1 build, instance B a 9-bit even-parity 2-stop build.
// Both run at 160 Clk per bit (TICK_DIV=10, OVERSAMPLE=16); serial frames are driven cycle by cycle.
// Table vectors cover nominal/parity/framing; hand sequences cover break, noise, overrun and mid-frame reset.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_rx, a_rdy, a_vld, a_rts;
    logic [7:0] a_dat;
    logic [2:0] a_err;
    logic       b_rst, b_rx, b_rdy, b_vld, b_rts;
    logic [8:0] b_dat;
    logic [2:0] b_err;

    uart_rx_frame #(
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
        .SYSCLOCK_FREQ(1600000), .BAUDRATE(10000), .OVERSAMPLE(16)
    ) u_a (
        .Clk(clk), .Rst(a_rst), .Rx_In(a_rx), .Rx_Ready(a_rdy),
        .Rx_Valid(a_vld), .Rx_Data_Out(a_dat), .Rx_Error(a_err), .RTS(a_rts)
    );

    uart_rx_frame #(
        .DATA_BITS(9), .PARITY(2), .STOP_BITS(2),
        .SYSCLOCK_FREQ(1600000), .BAUDRATE(10000), .OVERSAMPLE(16)
    ) u_b (
        .Clk(clk), .Rst(b_rst), .Rx_In(b_rx), .Rx_Ready(b_rdy),
        .Rx_Valid(b_vld), .Rx_Data_Out(b_dat), .Rx_Error(b_err), .RTS(b_rts)
    );

    int total = 0;
    int bad   = 0;

    // Accepted-word monitor, sampled shortly after each rising edge.
    int         a_words = 0, b_words = 0, a_rts_low = 0, b_rts_low = 0;
    logic [8:0] a_last_dat, b_last_dat;
    logic [2:0] a_last_err, b_last_err;
    always @(posedge clk) begin
        #2;
        if (a_vld === 1'b1 && a_rdy === 1'b1) begin
            a_words++;
            a_last_dat = {1'b0, a_dat};
            a_last_err = a_err;
        end
        if (b_vld === 1'b1 && b_rdy === 1'b1) begin
            b_words++;
            b_last_dat = b_dat;
            b_last_err = b_err;
        end
        if (a_rts === 1'b0) a_rts_low++;
        if (b_rts === 1'b0) b_rts_low++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame starting at the current falling edge. Optional 10-cycle high glitch
    // starting glitch_at cycles into the frame, and a one-cycle Rx_Ready pulse on A at rdy_at.
    task automatic send(input bit inst, input logic [8:0] d, input int nd, input bit has_par,
                        input bit par, input int nstop, input bit stopv,
                        input int glitch_at, input int rdy_at);
        logic [15:0] bits;
        int          idx;
        int          nb;
        logic        v;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[1+i] = d[i];
        idx = 1 + nd;
        if (has_par) begin
            bits[idx] = par;
            idx++;
        end
        for (int s = 0; s < nstop; s++) bits[idx+s] = stopv;
        nb = idx + nstop;
        for (int c = 0; c < nb * BIT_CLKS; c++) begin
            v = bits[c / BIT_CLKS];
            if (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 10) v = 1'b1;
            if (inst) b_rx = v; else a_rx = v;
            if (c == rdy_at)     a_rdy = 1'b1;
            if (c == rdy_at + 1) a_rdy = 1'b0;
            @(negedge clk);
        end
        if (inst) b_rx = 1'b1; else a_rx = 1'b1;
    endtask

    typedef struct {
        bit         inst;
        logic [8:0] dat;
        bit         par;
        bit         stopv;
        logic [8:0] exp_dat;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs[8];
    int   w0, r0;

    initial begin
        // inst, data, parity bit (B only), stop level, expected data, expected error
        vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 3'b000};
        vecs[1] = '{1'b0, 9'h055, 1'b0, 1'b0, 9'h055, 3'b010};
        vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 3'b000};
        vecs[3] = '{1'b0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 3'b000};
        vecs[4] = '{1'b1, 9'h03C, 1'b1, 1'b1, 9'h03C, 3'b001};
        vecs[5] = '{1'b1, 9'h03C, 1'b0, 1'b1, 9'h03C, 3'b000};
        vecs[6] = '{1'b1, 9'h0C3, 1'b1, 1'b0, 9'h0C3, 3'b011};
        vecs[7] = '{1'b1, 9'h1FF, 1'b1, 1'b1, 9'h1FF, 3'b000};

        a_rst = 1'b1; b_rst = 1'b1;
        a_rx  = 1'b1; b_rx  = 1'b1;
        a_rdy = 1'b1; b_rdy = 1'b1;
        wait_cyc(4);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("reset_a_vld", a_vld, 0);
        check("reset_a_dat", a_dat, 0);
        check("reset_a_err", a_err, 0);
        check("reset_a_rts", a_rts, 1);
        check("reset_b_vld", b_vld, 0);
        check("reset_b_dat", b_dat, 0);
        check("reset_b_rts", b_rts, 1);
        wait_cyc(20);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].inst) begin
                w0 = b_words; r0 = b_rts_low;
                send(1'b1, vecs[i].dat, 9, 1'b1, vecs[i].par, 2, vecs[i].stopv, -1, -100);
                wait_cyc(BIT_CLKS);
                check($sformatf("vec%0d_words", i), b_words - w0, 1);
                check($sformatf("vec%0d_rts_low", i), b_rts_low - r0, 1);
                check($sformatf("vec%0d_dat", i), b_last_dat, vecs[i].exp_dat);
                check($sformatf("vec%0d_err", i), b_last_err, vecs[i].exp_err);
            end else begin
                w0 = a_words; r0 = a_rts_low;
                send(1'b0, vecs[i].dat, 8, 1'b0, 1'b0, 1, vecs[i].stopv, -1, -100);
                wait_cyc(BIT_CLKS);
                check($sformatf("vec%0d_words", i), a_words - w0, 1);
                check($sformatf("vec%0d_rts_low", i), a_rts_low - r0, 1);
                check($sformatf("vec%0d_dat", i), a_last_dat, vecs[i].exp_dat);
                check($sformatf("vec%0d_err", i), a_last_err, vecs[i].exp_err);
            end
        end

        // Break: line low for three frame times gives exactly one zero word with framing error.
        w0 = a_words;
        a_rx = 1'b0;
        wait_cyc(3 * 10 * BIT_CLKS);
        check("break_words_low", a_words - w0, 1);
        check("break_dat", a_last_dat, 0);
        check("break_err", a_last_err, 3'b010);
        a_rx = 1'b1;
        wait_cyc(2 * BIT_CLKS);
        check("break_words_high", a_words - w0, 1);
        send(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, -1, -100);
        wait_cyc(BIT_CLKS);
        check("after_break_words", a_words - w0, 2);
        check("after_break_dat", a_last_dat, 9'h05A);
        check("after_break_err", a_last_err, 0);

        // Noise: a 40-cycle low pulse is a false start; then a glitch on the bit-3 decision.
        w0 = a_words;
        a_rx = 1'b0;
        wait_cyc(40);
        a_rx = 1'b1;
        wait_cyc(2 * BIT_CLKS);
        check("false_start_words", a_words - w0, 0);
        send(1'b0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 736, -100);
        wait_cyc(BIT_CLKS);
        check("glitch_words", a_words - w0, 1);
        check("glitch_dat", a_last_dat, 0);
        check("glitch_err", a_last_err, 0);

        // Overrun: second frame dropped while the first is held.
        a_rdy = 1'b0;
        send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1, -100);
        wait_cyc(BIT_CLKS);
        send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, -1, -100);
        wait_cyc(BIT_CLKS);
        check("ovr_vld", a_vld, 1);
        check("ovr_dat", a_dat, 8'h11);
        check("ovr_err", a_err, 3'b100);
        check("ovr_rts", a_rts, 0);
        a_rdy = 1'b1;
        @(negedge clk);
        a_rdy = 1'b0;
        check("ovr_acc_vld", a_vld, 0);
        check("ovr_acc_err", a_err, 0);
        check("ovr_acc_dat", a_dat, 8'h11);

        // Accept the held word in the same cycle the next frame completes: new word loads cleanly.
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        wait_cyc(20);
        send(1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1, -100);
        wait_cyc(BIT_CLKS);
        check("same_cyc_first_dat", a_dat, 8'h11);
        send(1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1542);
        wait_cyc(BIT_CLKS);
        check("same_cyc_vld", a_vld, 1);
        check("same_cyc_dat", a_dat, 8'h22);
        check("same_cyc_err", a_err, 0);
        a_rdy = 1'b1;
        wait_cyc(4);

        // Reset pulse in the middle of data bit 4 of a B frame.
        w0 = b_words;
        b_rx = 1'b0;
        wait_cyc(5 * BIT_CLKS + BIT_CLKS / 2);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        b_rx  = 1'b1;
        @(negedge clk);
        check("midrst_vld", b_vld, 0);
        check("midrst_dat", b_dat, 0);
        check("midrst_err", b_err, 0);
        check("midrst_rts", b_rts, 1);
        wait_cyc(13 * BIT_CLKS);
        check("midrst_words", b_words - w0, 0);
        send(1'b1, 9'h0C3, 9, 1'b1, 1'b0, 2, 1'b1, -1, -100);
        wait_cyc(BIT_CLKS);
        check("post_rst_words", b_words - w0, 1);
        check("post_rst_dat", b_last_dat, 9'h0C3);
        check("post_rst_err", b_last_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver for the serial front end. It runs entirely in the `Clk` domain and generates no derived clocks. It oversamples `Rx_In` and recovers bits by a 3-sample majority vote, and supports a configurable data width, parity mode and stop-bit count. Each received word goes into a one-entry output register behind a valid/ready handshake, with parity, framing and overrun status; the register feeds the RX FIFO.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `SYSCLOCK_FREQ`, 100000000: `Clk` frequency in Hz.
- `BAUDRATE`, 9600: line rate in baud.
- `OVERSAMPLE`, 16: ticks per bit, 8 or 16.
- Derived `TICK_DIV` = SYSCLOCK_FREQ/(BAUDRATE*OVERSAMPLE), integer division. Elaboration error if `TICK_DIV` < 2.
- `Clk`  in  1  the block's single clock.
- `Rst`  in  1  reset, synchronous and active-high.
- `Rx_In`  in  1  asynchronous serial line; idles high.
- `Rx_Ready`  in  1  downstream accepts the word this cycle.
- `Rx_Valid`  out  1  the output register holds an unaccepted word.
- `Rx_Data_Out`  out  DATA_BITS  received word.
- `Rx_Error`  out  3  status of the held word: [0] parity, [1] framing, [2] overrun.
- `RTS`  out  1  equals !Rx_Valid.

## Operation
- **Synchroniser:** `Rx_In` passes through a 2-flop synchroniser, reset to 1. All logic below uses the synchronised line `rxs`.
- **Tick generator:** counter runs 0..TICK_DIV-1 and pulses `tick` for one `Clk` on wrap. It is held at 0 in IDLE and restarts at 0 on start detection, so bit phase is aligned to the falling edge.
- **Sample counter:** counts 0..OVERSAMPLE-1 per bit, advancing on `tick`. Samples are taken at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority (2 of 3), decided on the tick at count OVERSAMPLE/2+1.
- **Arming:** an `armed` flag clears on reset and on any framing error. It sets when `rxs`=1 is observed in IDLE. Start detection requires `armed`.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `rxs`=0 and `armed`.
  - START, decision point: majority 1 → IDLE (false start, nothing output, no error); majority 0 → DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the received bit with the computed parity of the data bits; a mismatch sets the frame's parity flag.
  - STOP: sample STOP_BITS bits. Any stop bit with majority 0 sets the frame's framing flag. At the decision point of the final stop bit → IDLE and complete the frame. The next start edge can be detected in the following cycle, which gives a half-bit margin for back-to-back frames.
- **Completion, output register free** (`Rx_Valid`=0, or `Rx_Valid`&&`Rx_Ready` in the same cycle):
  - Load data and {0, framing, parity} into the output register.
  - `Rx_Valid` ← 1.
- **Completion, output register occupied and not being accepted:**
  - The new frame is discarded.
  - Held data is unchanged.
  - `Rx_Error[2]` ← 1.
- **Accept:** `Rx_Valid`&&`Rx_Ready` with no simultaneous completion → `Rx_Valid` ← 0 and `Rx_Error` ← 0. `Rx_Data_Out` holds its last value.
- **Break:** line low for a whole frame yields one word, data 0 with the framing flag set. No further start is accepted until the line returns high (arming rule).
- **Rst:** applies in any state, including mid-frame. Next cycle: state IDLE, counters 0, partial frame discarded.

## Timing
- Reset values: `Rx_Valid`=0, `Rx_Data_Out`=0, `Rx_Error`=0, `RTS`=1, synchroniser=1, `armed`=0.
- Start recognition: 2 `Clk` after the `Rx_In` falling edge (synchroniser), plus 1 to enter START.
- Bit decision points fall at (OVERSAMPLE/2+2) ticks into each bit, measured from the start-edge alignment.
- `Rx_Valid` rises in the `Clk` following the tick of the final stop-bit decision.
- Registered outputs: `Rx_Valid`, `Rx_Data_Out` and `Rx_Error` change on the same edge.
- `RTS` is combinational from `Rx_Valid`.
- Handshake is a standard valid/ready transfer; the data is held stable while `Rx_Valid`=1 and `Rx_Ready`=0.
- Throughput: one word per frame time. There is no internal queue beyond the single output register.

## Test plan
Bench parameters: SYSCLOCK_FREQ=1600000, BAUDRATE=10000, OVERSAMPLE=16, giving TICK_DIV=10 and 160 `Clk` per bit.
- **8N1 nominal:** 8N1 frame 0xA5 with `Rx_Ready`=1 → one-cycle `Rx_Valid`, `Rx_Data_Out`=0xA5, `Rx_Error`=000, `RTS` low for exactly that cycle.
- **Parity:** PARITY=2, frame 0x3C sent with parity bit 1 → data 0x3C, `Rx_Error`=001. The same frame with parity bit 0 → `Rx_Error`=000.
- **Framing and break:** stop bit driven 0 on frame 0x55 → `Rx_Error`=010. Then a line held low for 3 frame times → exactly one word, 0x00 with error 010. No further word until the line goes high and a new frame is sent.
- **Noise rejection:** `Rx_In` low for 40 `Clk` from idle → no `Rx_Valid`, state returns to IDLE. A 10-`Clk` high glitch centred on the bit-3 decision of frame 0x00 → data 0x00.
- **Overrun:** frames 0x11 then 0x22 with `Rx_Ready`=0 → data 0x11, error 100. Assert `Rx_Ready` → `Rx_Valid`=0. In a separate run, accept 0x11 in the same cycle 0x22 completes → 0x22 is loaded, error 000.
- **Reset mid-frame:** assert `Rst` for 1 cycle during bit 4 of a frame → all outputs at reset values and no word from that frame. A following 0xC3 frame (9-bit, STOP_BITS=2 build) → received correctly.
